// File: rtl/nn_layer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : nn_layer_if                                                      |
// | Brief   : Run control, weight/bias write port and result bus of one layer. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface nn_layer_if #(
    parameter int BIT_WIDTH   = 9,
    parameter int MAX_INPUTS  = 16,
    parameter int MAX_NEURONS = 16
);
    localparam int c_in_cnt_w  = $clog2(MAX_INPUTS + 1);
    localparam int c_neu_cnt_w = $clog2(MAX_NEURONS + 1);
    localparam int c_in_idx_w  = $clog2(MAX_INPUTS);
    localparam int c_neu_idx_w = $clog2(MAX_NEURONS);

    logic                                    start;
    logic [c_in_cnt_w-1:0]                   cfg_num_inputs;
    logic [c_neu_cnt_w-1:0]                  cfg_num_neurons;
    logic                                    relu_en;
    logic [MAX_INPUTS-1:0][BIT_WIDTH-1:0]    inputs;
    logic                                    w_we;
    logic                                    b_we;
    logic [c_neu_idx_w-1:0]                  w_addr_n;
    logic [c_in_idx_w-1:0]                   w_addr_i;
    logic [BIT_WIDTH-1:0]                    w_data;
    logic                                    busy;
    logic                                    done;
    logic                                    wr_err;
    logic [MAX_NEURONS-1:0][BIT_WIDTH-1:0]   outputs;

    modport master (
        output start, cfg_num_inputs, cfg_num_neurons, relu_en, inputs,
        output w_we, b_we, w_addr_n, w_addr_i, w_data,
        input  busy, done, wr_err, outputs
    );

    modport slave (
        input  start, cfg_num_inputs, cfg_num_neurons, relu_en, inputs,
        input  w_we, b_we, w_addr_n, w_addr_i, w_data,
        output busy, done, wr_err, outputs
    );
endinterface
`default_nettype wire

// File: rtl/nn_layer_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : nn_layer_engine                                                  |
// | Brief   : Time-multiplexed fully-connected layer, one MAC, sign-magnitude. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module nn_layer_engine #(
    parameter int FRACTION_WIDTH = 4,
    parameter int BIT_WIDTH      = 9,
    parameter int MAX_INPUTS     = 16,
    parameter int MAX_NEURONS    = 16
) (
    input  wire logic  clk,
    input  wire logic  rst,
    nn_layer_if.slave  bus
);
    localparam int c_mag_w     = BIT_WIDTH - 1;
    localparam int c_acc_w     = 2 * BIT_WIDTH + $clog2(MAX_INPUTS) + 1;
    localparam int c_in_cnt_w  = $clog2(MAX_INPUTS + 1);
    localparam int c_neu_cnt_w = $clog2(MAX_NEURONS + 1);
    localparam int c_in_idx_w  = $clog2(MAX_INPUTS);
    localparam int c_neu_idx_w = $clog2(MAX_NEURONS);
    localparam logic signed [c_acc_w-1:0] c_sat_pos = c_acc_w'((2 ** c_mag_w) - 1);
    localparam logic signed [c_acc_w-1:0] c_sat_neg = -c_sat_pos;

    localparam logic [2:0] c_idle = 3'd0;
    localparam logic [2:0] c_load = 3'd1;
    localparam logic [2:0] c_mac  = 3'd2;
    localparam logic [2:0] c_wb   = 3'd3;
    localparam logic [2:0] c_done = 3'd4;

    logic [2:0]                             state_q, state_d;
    logic [c_neu_idx_w-1:0]                 n_q, n_d;
    logic [c_in_idx_w-1:0]                  i_q, i_d;
    logic [c_in_cnt_w-1:0]                  num_in_q, num_in_d;
    logic [c_neu_cnt_w-1:0]                 num_neu_q, num_neu_d;
    logic                                   relu_q, relu_d;
    logic [MAX_INPUTS-1:0][BIT_WIDTH-1:0]   x_q, x_d;
    logic signed [c_acc_w-1:0]              acc_q, acc_d;
    logic [BIT_WIDTH-1:0]                   w_mem_q [MAX_NEURONS][MAX_INPUTS];
    logic [BIT_WIDTH-1:0]                   w_mem_d [MAX_NEURONS][MAX_INPUTS];
    logic [BIT_WIDTH-1:0]                   b_mem_q [MAX_NEURONS];
    logic [BIT_WIDTH-1:0]                   b_mem_d [MAX_NEURONS];
    logic [MAX_NEURONS-1:0][BIT_WIDTH-1:0]  outputs_q, outputs_d;
    logic                                   busy_q, busy_d;
    logic                                   done_q, done_d;
    logic                                   wr_err_q, wr_err_d;

    logic [c_in_cnt_w-1:0]                  w_num_in;
    logic [c_neu_cnt_w-1:0]                 w_num_neu;
    logic                                   w_last_i, w_last_n, w_wr_ok;
    logic [BIT_WIDTH-1:0]                   w_x, w_w;
    logic [2*c_mag_w-1:0]                   w_prod_full, w_prod_shr;
    logic signed [c_acc_w-1:0]              w_prod_ext, w_prod, w_res;
    logic                                   w_res_neg;
    logic [c_mag_w-1:0]                     w_res_abs;
    logic [BIT_WIDTH-1:0]                   w_out;
    logic [c_neu_idx_w-1:0]                 w_n_next;

    function automatic logic signed [c_acc_w-1:0] sm_to_acc(input logic [BIT_WIDTH-1:0] v);
        logic signed [c_acc_w-1:0] m;
        m = signed'({{(c_acc_w - c_mag_w){1'b0}}, v[c_mag_w-1:0]});
        return v[BIT_WIDTH-1] ? -m : m;
    endfunction

    // A zero or oversized shape request selects the full-size layer
    assign w_num_in  = (bus.cfg_num_inputs == '0 || bus.cfg_num_inputs > c_in_cnt_w'(MAX_INPUTS))
                     ? c_in_cnt_w'(MAX_INPUTS) : bus.cfg_num_inputs;
    assign w_num_neu = (bus.cfg_num_neurons == '0 || bus.cfg_num_neurons > c_neu_cnt_w'(MAX_NEURONS))
                     ? c_neu_cnt_w'(MAX_NEURONS) : bus.cfg_num_neurons;
    assign w_last_i  = (c_in_cnt_w'(i_q) == num_in_q - c_in_cnt_w'(1));
    assign w_last_n  = (c_neu_cnt_w'(n_q) == num_neu_q - c_neu_cnt_w'(1));
    assign w_n_next  = n_q + c_neu_idx_w'(1);
    assign w_wr_ok   = (state_q == c_idle) && !bus.start;

    assign w_x         = x_q[i_q];
    assign w_w         = w_mem_q[n_q][i_q];
    assign w_prod_full = w_x[c_mag_w-1:0] * w_w[c_mag_w-1:0];
    assign w_prod_shr  = w_prod_full >> FRACTION_WIDTH;
    assign w_prod_ext  = signed'({{(c_acc_w - 2*c_mag_w){1'b0}}, w_prod_shr});
    assign w_prod      = (w_x[BIT_WIDTH-1] ^ w_w[BIT_WIDTH-1]) ? -w_prod_ext : w_prod_ext;

    always_comb begin
        w_res = acc_q;
        if (relu_q && acc_q < 0)    w_res = '0;
        else if (acc_q > c_sat_pos) w_res = c_sat_pos;
        else if (acc_q < c_sat_neg) w_res = c_sat_neg;
    end
    // The sign bit follows the two's-complement sign, so zero never comes out negative
    assign w_res_neg = w_res < 0;
    assign w_res_abs = c_mag_w'(w_res_neg ? -w_res : w_res);
    assign w_out     = {w_res_neg, w_res_abs};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= c_idle;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_idle:  if (bus.start) state_d = c_load;
            c_load:  state_d = c_mac;
            c_mac:   if (w_last_i) state_d = c_wb;
            c_wb:    state_d = w_last_n ? c_done : c_mac;
            c_done:  state_d = c_idle;
            default: state_d = c_idle;
        endcase
    end

    always_comb begin
        busy_d = (state_q == c_load) || (state_q == c_mac) || (state_q == c_wb);
        done_d = (state_q == c_done);
    end

    always_comb begin
        n_d       = n_q;
        i_d       = i_q;
        num_in_d  = num_in_q;
        num_neu_d = num_neu_q;
        relu_d    = relu_q;
        x_d       = x_q;
        acc_d     = acc_q;
        w_mem_d   = w_mem_q;
        b_mem_d   = b_mem_q;
        outputs_d = outputs_q;
        wr_err_d  = (bus.w_we || bus.b_we) && !w_wr_ok;
        if (w_wr_ok && bus.w_we) w_mem_d[bus.w_addr_n][bus.w_addr_i] = bus.w_data;
        if (w_wr_ok && bus.b_we) b_mem_d[bus.w_addr_n] = bus.w_data;
        case (state_q)
            c_load: begin
                x_d       = bus.inputs;
                relu_d    = bus.relu_en;
                num_in_d  = w_num_in;
                num_neu_d = w_num_neu;
                n_d       = '0;
                i_d       = '0;
                acc_d     = sm_to_acc(b_mem_q[0]);
                for (int k = 0; k < MAX_NEURONS; k++)
                    if (k >= int'(w_num_neu)) outputs_d[k] = '0;
            end
            c_mac: begin
                acc_d = acc_q + w_prod;
                if (!w_last_i) i_d = i_q + c_in_idx_w'(1);
            end
            c_wb: begin
                outputs_d[n_q] = w_out;
                if (!w_last_n) begin
                    n_d   = w_n_next;
                    i_d   = '0;
                    acc_d = sm_to_acc(b_mem_q[w_n_next]);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n_q       <= '0;
            i_q       <= '0;
            num_in_q  <= '0;
            num_neu_q <= '0;
            relu_q    <= 1'b0;
            x_q       <= '0;
            acc_q     <= '0;
            w_mem_q   <= '{default: '0};
            b_mem_q   <= '{default: '0};
            outputs_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            wr_err_q  <= 1'b0;
        end else begin
            n_q       <= n_d;
            i_q       <= i_d;
            num_in_q  <= num_in_d;
            num_neu_q <= num_neu_d;
            relu_q    <= relu_d;
            x_q       <= x_d;
            acc_q     <= acc_d;
            w_mem_q   <= w_mem_d;
            b_mem_q   <= b_mem_d;
            outputs_q <= outputs_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            wr_err_q  <= wr_err_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.wr_err  = wr_err_q;
    assign bus.outputs = outputs_q;
endmodule
`default_nettype wire

// File: doc/nn_layer_engine.md
Name: nn_layer_engine

Overview:
- Runtime-configurable, time-multiplexed fully-connected layer: one MAC, iterates neurons × inputs, adds per-neuron bias, optional ReLU, saturates to sign-magnitude output.
- Successor to the fixed 2-4-4-1 hard-wired net. Weights and biases are loadable through a write port instead of constants.
- The layer shape is chosen per run. A top-level sequencer chains instances (or re-runs one) to build multi-layer nets.

Parameters:
- FRACTION_WIDTH, 4, fractional bits of every datum.
- BIT_WIDTH, 9, datum width. MSB is the sign, BIT_WIDTH-1 bits are magnitude (sign-magnitude).
- MAX_INPUTS, 16, maximum input units per layer.
- MAX_NEURONS, 16, maximum neurons per layer.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle run request; sampled only in IDLE.
- cfg_num_inputs  in  $clog2(MAX_INPUTS+1)  active inputs I for the run.
- cfg_num_neurons  in  $clog2(MAX_NEURONS+1)  active neurons N for the run.
- relu_en  in  1  1 = apply ReLU before saturation.
- inputs  in  [MAX_INPUTS] x BIT_WIDTH  layer input vector (sign-magnitude).
- w_we  in  1  weight write strobe.
- b_we  in  1  bias write strobe.
- w_addr_n  in  $clog2(MAX_NEURONS)  neuron index for the weight/bias write.
- w_addr_i  in  $clog2(MAX_INPUTS)  input index for the weight write.
- w_data  in  BIT_WIDTH  weight/bias value.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when outputs are valid.
- wr_err  out  1  one-cycle pulse when a write is attempted while busy.
- outputs  out  [MAX_NEURONS] x BIT_WIDTH  results (sign-magnitude).

Behaviour:
- Reset (rst=0, async): FSM to IDLE.
  - busy, done and wr_err are 0.
  - All outputs entries, weight RAM, bias RAM and the accumulator are 0.
- FSM states and transitions:
  - IDLE: start=1 → LOAD.
  - LOAD: latch inputs, relu_en and clamped cfg; set n=0, i=0; acc=bias[0] sign-extended to two's complement; → MAC.
  - MAC: acc += product(x[i], w[n][i]) each cycle. When i==I-1 → WB, else i++.
  - WB: write outputs[n]. If n==N-1 → DONE; else n++, i=0, acc=bias[n+1], → MAC.
  - DONE: done=1 for one cycle → IDLE.
- Latency: done is high exactly 2+N*(I+1) cycles after the clock edge that sampled start.
  - Example: I=2, N=1 gives 5.
- Config clamp: value 0 or above the max is treated as the max (MAX_INPUTS / MAX_NEURONS).
- Product rules:
  - magnitude = (|x|*|w|) >> FRACTION_WIDTH, truncated toward zero.
  - sign = sx XOR sw.
  - Result is converted to two's complement and sign-extended into the accumulator.
- Accumulator: width 2*BIT_WIDTH + $clog2(MAX_INPUTS) + 1, two's complement. It never overflows internally.
- Writeback:
  - If relu_en and acc<0, the result is 0.
  - Otherwise clamp to ±(2^(BIT_WIDTH-1)-1), then convert to sign-magnitude.
  - Zero is always emitted as sign=0 (no negative zero).
- outputs entries n ≥ N are written 0 during the run. outputs holds its value between runs.
- Writes:
  - Accepted only when the FSM is in IDLE (and not in the cycle start is sampled).
  - w_we writes w[w_addr_n][w_addr_i]; b_we writes bias[w_addr_n].
  - If both strobes are asserted, both are written.
  - A write while the FSM is not IDLE, or coincident with start, is dropped and wr_err pulses the next cycle.
- start while busy or in DONE is ignored; no error flag is raised.
- Reset mid-run: immediate return to IDLE. done never pulses for the aborted run. All storage is cleared.

Test Plan:
- Reset: assert rst=0 mid-idle → busy=0, done=0, all outputs=0x000. After release, a run with no writes gives all outputs 0x000.
- Basic MAC (I=2, N=1, relu_en=0):
  - Stimulus: x={0x010, 0x020}, w={0x008, 0x118}, bias 0x004.
  - Expected: outputs[0]=0x124 (-2.25), done exactly 5 cycles after start, busy high cycles 1-4.
  - Rerun with relu_en=1 → outputs[0]=0x000.
- Saturation (I=2, N=2):
  - All x=0x0FF; w[0]=0x0FF, w[1]=0x1FF, biases 0.
  - Expected: outputs[0]=0x0FF, outputs[1]=0x1FF, outputs[2..15]=0x000.
- Negative zero and truncation:
  - x=0x100 (-0), w=0x010, bias 0 → 0x000.
  - x=0x001, w=0x001 → product truncates to 0 → 0x000.
- Collisions:
  - During a run, pulse start and w_we (w[0][0]=0x010) → run completes once, wr_err pulses once.
  - A second run shows the old weight still in use.
  - w_we asserted in the same cycle as start → dropped, wr_err pulses.
- Reset mid-MAC: rst=0 in the 3rd MAC cycle → busy=0 immediately, no done pulse, then weights read back as 0 (the next run gives 0x000).
